// File: rtl/wdt_reset_sequencer.sv
// Firmware heartbeat watchdog plus software reset request, merged into one
// staged reset event: domains assert in ascending order, hold, release descending, then cool down.
module wdt_reset_sequencer #(
    parameter int          NUM_DOMAINS     = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned WARN_CYCLES     = 100_000_000,
    parameter int          STAGE_GAP       = 4,
    parameter int          HOLD_CYCLES     = 5,
    parameter int          COOLDOWN_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wdt_enable,
    input  logic                   kick,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   warn_irq,
    output logic                   busy,
    output logic [1:0]             reset_cause,
    output logic [7:0]             reset_count
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [31:0]      TO_M1    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      WARN_TH  = 32'(TIMEOUT_CYCLES - WARN_CYCLES);
    localparam logic [15:0]      GAP_M1   = 16'(STAGE_GAP - 1);
    localparam logic [15:0]      HOLD_M1  = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0]      COOL_M1  = 16'(COOLDOWN_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [2:0] {
        S_DISARMED,
        S_ARMED,
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_COOLDOWN
    } state_e;

    state_e                 state_q;
    logic [31:0]            wdt_cnt_q;
    logic [31:0]            wdt_cnt_d;
    logic [15:0]            sub_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] domain_q;
    logic                   warn_q;
    logic                   busy_q;
    logic [1:0]             cause_q;
    logic [7:0]             count_q;

    logic wdt_timeout;
    logic sw_trig;
    logic trigger;

    // A kick on the would-be timeout edge suppresses the timeout.
    assign wdt_timeout = (state_q == S_ARMED) && !kick && (wdt_cnt_q == TO_M1);
    assign sw_trig     = ((state_q == S_DISARMED) || (state_q == S_ARMED)) && sw_reset_req;
    assign trigger     = wdt_timeout || sw_trig;

    always_comb begin
        wdt_cnt_d = '0;
        if ((state_q == S_ARMED) && wdt_enable && !kick && !trigger) begin
            wdt_cnt_d = wdt_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_DISARMED;
            wdt_cnt_q <= '0;
            sub_q     <= '0;
            idx_q     <= '0;
            domain_q  <= '0;
            warn_q    <= 1'b0;
            busy_q    <= 1'b0;
            cause_q   <= 2'b00;
            count_q   <= 8'd0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            if (trigger) begin
                domain_q <= NUM_DOMAINS'(1);
                busy_q   <= 1'b1;
                warn_q   <= 1'b0;
                cause_q  <= {sw_trig, wdt_timeout};
                count_q  <= (count_q == 8'd255) ? count_q : count_q + 8'd1;
                sub_q    <= '0;
                idx_q    <= IDX_W'(1);
                state_q  <= (NUM_DOMAINS == 1) ? S_HOLD : S_ASSERT;
            end else begin
                case (state_q)
                    S_DISARMED: begin
                        warn_q <= 1'b0;
                        if (wdt_enable) state_q <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (!wdt_enable) begin
                            warn_q  <= 1'b0;
                            state_q <= S_DISARMED;
                        end else begin
                            warn_q <= (wdt_cnt_d >= WARN_TH);
                        end
                    end
                    S_ASSERT: begin
                        if (sub_q == GAP_M1) begin
                            domain_q[idx_q] <= 1'b1;
                            sub_q           <= '0;
                            if (idx_q == LAST_IDX) state_q <= S_HOLD;
                            else                   idx_q   <= idx_q + 1'b1;
                        end else begin
                            sub_q <= sub_q + 16'd1;
                        end
                    end
                    S_HOLD: begin
                        if (sub_q == HOLD_M1) begin
                            domain_q[NUM_DOMAINS-1] <= 1'b0;
                            sub_q   <= '0;
                            idx_q   <= LAST_IDX - 1'b1;
                            state_q <= (NUM_DOMAINS == 1) ? S_COOLDOWN : S_RELEASE;
                        end else begin
                            sub_q <= sub_q + 16'd1;
                        end
                    end
                    S_RELEASE: begin
                        if (sub_q == GAP_M1) begin
                            domain_q[idx_q] <= 1'b0;
                            sub_q           <= '0;
                            if (idx_q == '0) state_q <= S_COOLDOWN;
                            else             idx_q   <= idx_q - 1'b1;
                        end else begin
                            sub_q <= sub_q + 16'd1;
                        end
                    end
                    S_COOLDOWN: begin
                        // Requests arriving here, including on the exit edge, are dropped.
                        if (sub_q == COOL_M1) begin
                            busy_q  <= 1'b0;
                            sub_q   <= '0;
                            state_q <= wdt_enable ? S_ARMED : S_DISARMED;
                        end else begin
                            sub_q <= sub_q + 16'd1;
                        end
                    end
                    default: state_q <= S_DISARMED;
                endcase
            end
        end
    end

    assign domain_reset = domain_q;
    assign warn_irq     = warn_q;
    assign busy         = busy_q;
    assign reset_cause  = cause_q;
    assign reset_count  = count_q;

endmodule

// File: tb/tb_wdt_reset_sequencer.sv
// Bench for wdt_reset_sequencer: per-edge expected domain/busy/cause/count
// records are queued when a trigger is driven and compared as each edge passes.
module tb_wdt_reset_sequencer;

    localparam int N = 4;
    localparam int G = 4;
    localparam int H = 5;
    localparam int C = 16;
    localparam int T = 20;
    localparam int W = 5;
    localparam int SEQ_LEN = (N-1)*G + H + (N-1)*G + C;   // edges from trigger to busy low

    logic         clk = 1'b0;
    logic         rst;
    logic         wdt_enable;
    logic         kick;
    logic         sw_reset_req;
    logic [N-1:0] domain_reset;
    logic         warn_irq;
    logic         busy;
    logic [1:0]   reset_cause;
    logic [7:0]   reset_count;

    wdt_reset_sequencer #(
        .NUM_DOMAINS(N), .TIMEOUT_CYCLES(T), .WARN_CYCLES(W),
        .STAGE_GAP(G), .HOLD_CYCLES(H), .COOLDOWN_CYCLES(C)
    ) dut (
        .clk(clk), .rst(rst), .wdt_enable(wdt_enable), .kick(kick),
        .sw_reset_req(sw_reset_req), .domain_reset(domain_reset),
        .warn_irq(warn_irq), .busy(busy), .reset_cause(reset_cause),
        .reset_count(reset_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           at;
        logic [N-1:0] dom;
        logic         bsy;
        logic [1:0]   cause;
        logic [7:0]   cnt;
    } exp_t;

    exp_t       sb[$];
    int         now = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] exp_cause = 2'b00;
    logic [7:0] exp_count = 8'd0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, now, act, exp);
        end
    endtask

    // Expected outputs for edges trig .. trig+SEQ_LEN, from the documented edge formula.
    task automatic push_seq(input int trig, input logic [1:0] cause);
        exp_t e;
        exp_cause = cause;
        if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
        for (int d = 0; d <= SEQ_LEN; d++) begin
            e.at    = trig + d;
            e.bsy   = (d < SEQ_LEN);
            e.cause = exp_cause;
            e.cnt   = exp_count;
            for (int i = 0; i < N; i++)
                e.dom[i] = (d >= i*G) && (d < (N-1)*G + H + (N-1-i)*G);
            sb.push_back(e);
        end
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0 && sb[0].at <= now) begin
            e = sb.pop_front();
            chk_eq("sb_domain", 32'(domain_reset), 32'(e.dom));
            chk_eq("sb_busy",   32'(busy),         32'(e.bsy));
            chk_eq("sb_cause",  32'(reset_cause),  32'(e.cause));
            chk_eq("sb_count",  32'(reset_count),  32'(e.cnt));
        end
    endtask

    task automatic tick(input logic k, input logic s);
        kick         = k;
        sw_reset_req = s;
        @(posedge clk);
        now++;
        #1;
        kick         = 1'b0;
        sw_reset_req = 1'b0;
        sb_check();
    endtask

    task automatic idle_quiet(input int n, input string tag);
        for (int j = 0; j < n; j++) begin
            tick(1'b0, 1'b0);
            chk_eq({tag, "_dom"},  32'(domain_reset), 32'd0);
            chk_eq({tag, "_busy"}, 32'(busy),         32'd0);
        end
    endtask

    initial begin
        int a;
        int trig;
        rst = 1'b1; wdt_enable = 1'b0; kick = 1'b0; sw_reset_req = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk_eq("rst_dom",   32'(domain_reset), 32'd0);
        chk_eq("rst_warn",  32'(warn_irq),     32'd0);
        chk_eq("rst_busy",  32'(busy),         32'd0);
        chk_eq("rst_cause", 32'(reset_cause),  32'd0);
        chk_eq("rst_count", 32'(reset_count),  32'd0);
        rst = 1'b0;
        idle_quiet(5, "disarmed");

        // Watchdog timeout with no kicks.
        wdt_enable = 1'b1;
        tick(1'b0, 1'b0);
        a = now;
        push_seq(a + T, 2'b01);
        for (int k = 1; k <= T + SEQ_LEN; k++) begin
            if (k == T + 1) wdt_enable = 1'b0;
            tick(1'b0, 1'b0);
            if (k <= T) chk_eq("to_warn", 32'(warn_irq), 32'((k >= T - W) && (k < T)));
            if (k <  T) chk_eq("to_pre_dom", 32'(domain_reset), 32'd0);
        end
        idle_quiet(30, "to_after");

        // Periodic kicks, then a kick on the timeout edge, then sw + timeout together.
        wdt_enable = 1'b1;
        tick(1'b0, 1'b0);
        a = now;
        for (int k = 1; k <= 200; k++) begin
            tick((k % 10) == 0, 1'b0);
            chk_eq("kick_warn", 32'(warn_irq),     32'd0);
            chk_eq("kick_dom",  32'(domain_reset), 32'd0);
        end
        for (int k = 201; k < 200 + T; k++) begin
            tick(1'b0, 1'b0);
            chk_eq("kick_warn2", 32'(warn_irq), 32'((k - 200) >= T - W));
        end
        tick(1'b1, 1'b0);
        chk_eq("kick_edge_warn", 32'(warn_irq),     32'd0);
        chk_eq("kick_edge_busy", 32'(busy),         32'd0);
        chk_eq("kick_edge_dom",  32'(domain_reset), 32'd0);
        for (int k = 1; k < T; k++) tick(1'b0, 1'b0);
        push_seq(now + 1, 2'b11);
        tick(1'b0, 1'b1);
        wdt_enable = 1'b0;
        for (int d = 1; d <= SEQ_LEN; d++) tick(1'b0, 1'b0);
        idle_quiet(30, "both_after");

        // Software request while disarmed, with requests/kicks during HOLD, COOLDOWN and on the exit edge.
        push_seq(now + 1, 2'b10);
        tick(1'b0, 1'b1);
        for (int d = 1; d <= SEQ_LEN; d++) begin
            logic poke;
            poke = (d == 14) || (d == 35) || (d == SEQ_LEN);
            tick(poke, poke);
        end
        // First accepted edge after the sequence: back-to-back event.
        push_seq(now + 1, 2'b10);
        tick(1'b0, 1'b1);
        for (int d = 1; d <= SEQ_LEN; d++) tick(1'b0, 1'b0);
        idle_quiet(30, "sw_after");

        // Drive reset_count into saturation.
        for (int s = 0; s < 256; s++) begin
            push_seq(now + 1, 2'b10);
            tick(1'b0, 1'b1);
            for (int d = 1; d <= SEQ_LEN; d++) tick(1'b0, 1'b0);
        end
        chk_eq("sat_count", 32'(reset_count), 32'd255);

        // rst in the middle of a sequence.
        push_seq(now + 1, 2'b10);
        tick(1'b0, 1'b1);
        trig = now;
        for (int d = 1; d <= 9; d++) tick(1'b0, 1'b0);
        chk_eq("mid_dom",  32'(domain_reset), 32'b0111);
        chk_eq("mid_busy", 32'(busy),         32'd1);
        sb.delete();
        rst = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        exp_cause = 2'b00;
        exp_count = 8'd0;
        chk_eq("mrst_dom",   32'(domain_reset), 32'd0);
        chk_eq("mrst_busy",  32'(busy),         32'd0);
        chk_eq("mrst_count", 32'(reset_count),  32'd0);
        chk_eq("mrst_cause", 32'(reset_cause),  32'd0);
        chk_eq("mrst_edge",  32'(now - trig),   32'd10);
        idle_quiet(40, "mrst_after");

        chk_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
